one_conv_ofm_writer: RTL and testbench
======================================

# one_conv_ofm_writer

Write-side counterpart of the 1x1-convolution IFM read sequencer. Accepts the stream of 13-column output chunks produced by the 1x1 conv engine, tracks the (chunk, row, output-channel) position, and issues linear write addresses and data to the OFM buffer through a one-stage registered valid/ready pipeline. It also emits row-done and frame-done pulses for the layer controller. Chunk order matches the read sequencer: chunk fastest, then row, then output channel.

## Interface
- DATA_W, 64: width of one packed 13-column output chunk.
- ADDR_W, 24: write address width; covers 32 chunks × 416 rows × 1024 channels.
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; latches configuration and arms the writer.
- ofm_width  in  9  spatial width/height (13, 26, 52, 104, 208 or 416).
- ofm_channel  in  11  output channel count, 1..1024.
- ofm_base  in  ADDR_W  base address (present only with ONE_CONV_OFM_BASE_EN).
- in_valid / in_ready  in / out  1  input chunk handshake.
- in_data  in  DATA_W  chunk payload.
- wr_valid / wr_ready  out / in  1  OFM buffer write handshake.
- wr_addr  out  ADDR_W  chunk write address.
- wr_data  out  DATA_W  chunk payload.
- row_done  out  1  pulse: last chunk of a row accepted at input.
- frame_done  out  1  pulse: last write of the layer accepted at output.
- busy  out  1  high from accepted start to frame_done.
- cfg_err  out  1  pulse: start with an unsupported width.

## Operation
- Width decode at start: w_last = 31/15/7/3/1/0 for 416/208/104/52/26/13. Any other width: cfg_err pulses for 1 cycle, state stays IDLE, nothing is latched.
- Latched registers: w_last, h_last = ofm_width−1, c_last = ofm_channel−1, addr base (0 without the macro).
- Counters (advance only on in_valid & in_ready): w_cnt 5 b, h_cnt 9 b, oc_cnt 11 b, addr_cnt ADDR_W. w_cnt wraps at w_last and carries into h_cnt. h_cnt wraps at h_last and carries into oc_cnt. addr_cnt increments by 1 per chunk, giving addr = base + (oc·W + h)·(w_last+1) + w.
- FSM:
  - IDLE: in_ready=0. A valid start moves to RUN and clears all counters.
  - RUN: accept chunks. Acceptance of the chunk where w, h and oc are all at last moves to DRAIN.
  - DRAIN: in_ready=0. When the output register empties (wr_valid & wr_ready), pulse frame_done and return to IDLE.
- start outside IDLE is ignored.
- row_done pulses on acceptance of a chunk with w_cnt==w_last, including the final chunk.
- Output register: in_ready = RUN & (~wr_valid | wr_ready). On accept, load wr_addr/wr_data and set wr_valid. wr_valid clears on wr_ready when there is no new accept.
- Arithmetic is unsigned. addr_cnt wraps modulo 2^ADDR_W, which cannot occur with legal configurations.

## Timing
- Reset values: in_ready=0, wr_valid=0, wr_addr=0, wr_data=0, row_done=0, frame_done=0, busy=0, cfg_err=0. FSM=IDLE, all counters 0.
- Latency: chunk accepted at edge N appears on wr_* after edge N. Full throughput is 1 chunk/cycle while wr_ready=1.
- wr_addr/wr_data are held stable while wr_valid & ~wr_ready.
- Simultaneous drain and accept: the register reloads in the same cycle with no bubble.
- row_done/cfg_err are registered and asserted the cycle after the triggering edge. frame_done is asserted in the cycle after the last output handshake, and busy falls in that same cycle.
- Reset mid-layer: returns to IDLE immediately, and any pending write is discarded.

## Configuration
- ONE_CONV_OFM_BASE_EN defined: the ofm_base port exists, is latched at start, and is added to every address.
- Not defined: no port, and addresses start at 0.

## Structure
- Shared package: width→w_last decode function, supported-width constants, state encoding, ADDR_W default.
- One sub-module: one_conv_ofm_pos_cnt, the w/h/oc nested counter with carry outputs. FSM and output register stay in the top.

## Test plan
- Width 13, 2 channels, wr_ready=1:
  - 26 chunks yield addresses 0..25.
  - row_done pulses 26 times.
  - frame_done pulses once, 1 cycle after the last write.
- Width 416, 1 channel:
  - chunk 32 gets address 32, with h_cnt=1, w_cnt=0.
  - the final address is 13311.
- Back-pressure with wr_ready toggled 1/0 randomly:
  - no chunk is lost or duplicated.
  - wr_addr/wr_data stay stable while stalled.
  - the address sequence stays strictly increasing.
- start with ofm_width=100: cfg_err pulses, busy stays 0, and in_ready stays 0.
- Assert rst after 10 chunks of width 26: all outputs return to reset values, and the next start restarts at address 0.
- With ONE_CONV_OFM_BASE_EN and ofm_base=0x1000, width 26, 1 channel: addresses run 0x1000..0x1033.

Source files
------------

// File: rtl/one_conv_ofm_pkg.sv
// Shared types and width decode for the 1x1-conv OFM writer.
package one_conv_ofm_pkg;

  localparam int unsigned AddrW = 24;
  localparam int unsigned DataW = 64;

  localparam logic [8:0] Width13  = 9'd13;
  localparam logic [8:0] Width26  = 9'd26;
  localparam logic [8:0] Width52  = 9'd52;
  localparam logic [8:0] Width104 = 9'd104;
  localparam logic [8:0] Width208 = 9'd208;
  localparam logic [8:0] Width416 = 9'd416;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  typedef struct packed {
    logic       ok;
    logic [4:0] w_last;
  } wdec_t;

  // Chunks per row minus one; ok=0 flags an unsupported width.
  function automatic wdec_t decode_w_last(input logic [8:0] width);
    wdec_t d;
    d.ok     = 1'b1;
    d.w_last = 5'd0;
    case (width)
      Width416: d.w_last = 5'd31;
      Width208: d.w_last = 5'd15;
      Width104: d.w_last = 5'd7;
      Width52:  d.w_last = 5'd3;
      Width26:  d.w_last = 5'd1;
      Width13:  d.w_last = 5'd0;
      default:  d.ok     = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/one_conv_ofm_writer_pos_cnt.sv
// Nested chunk/row/output-channel position counter with carry outputs.
module one_conv_ofm_pos_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        adv_i,
  input  logic [4:0]  w_last_i,
  input  logic [8:0]  h_last_i,
  input  logic [10:0] c_last_i,
  output logic        w_wrap_o,
  output logic        last_o
);

  logic [4:0]  w_cnt_q, w_cnt_d;
  logic [8:0]  h_cnt_q, h_cnt_d;
  logic [10:0] oc_cnt_q, oc_cnt_d;
  logic        h_at_last, oc_at_last;

  assign w_wrap_o   = (w_cnt_q == w_last_i);
  assign h_at_last  = (h_cnt_q == h_last_i);
  assign oc_at_last = (oc_cnt_q == c_last_i);
  assign last_o     = w_wrap_o & h_at_last & oc_at_last;

  always_comb begin
    w_cnt_d  = w_cnt_q;
    h_cnt_d  = h_cnt_q;
    oc_cnt_d = oc_cnt_q;
    if (clr_i) begin
      w_cnt_d  = '0;
      h_cnt_d  = '0;
      oc_cnt_d = '0;
    end else if (adv_i) begin
      if (w_wrap_o) begin
        w_cnt_d = '0;
        if (h_at_last) begin
          h_cnt_d  = '0;
          oc_cnt_d = oc_at_last ? 11'd0 : oc_cnt_q + 11'd1;
        end else begin
          h_cnt_d = h_cnt_q + 9'd1;
        end
      end else begin
        w_cnt_d = w_cnt_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_cnt_q  <= '0;
      h_cnt_q  <= '0;
      oc_cnt_q <= '0;
    end else begin
      w_cnt_q  <= w_cnt_d;
      h_cnt_q  <= h_cnt_d;
      oc_cnt_q <= oc_cnt_d;
    end
  end

endmodule

// File: rtl/one_conv_ofm_writer.sv
// 1x1-conv OFM writer: sequences chunk addresses and drives a registered write port.
// Optional ONE_CONV_OFM_BASE_EN adds an ofm_base port latched at start.
module one_conv_ofm_writer
  import one_conv_ofm_pkg::*;
#(
  parameter int unsigned DATA_W = DataW,
  parameter int unsigned ADDR_W = AddrW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [8:0]        ofm_width,
  input  logic [10:0]       ofm_channel,
`ifdef ONE_CONV_OFM_BASE_EN
  input  logic [ADDR_W-1:0] ofm_base,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              row_done,
  output logic              frame_done,
  output logic              busy,
  output logic              cfg_err
);

  state_e              state_q, state_d;
  logic [4:0]          w_last_q;
  logic [8:0]          h_last_q;
  logic [10:0]         c_last_q;
  logic [ADDR_W-1:0]   base_q, base_in;
  logic [ADDR_W-1:0]   addr_cnt_q, addr_cnt_d;
  logic                wr_valid_q, wr_valid_d;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic                row_done_q, frame_done_d, frame_done_q, cfg_err_d, cfg_err_q;
  logic                accept, cfg_load, w_wrap, pos_last;
  wdec_t               dec;

`ifdef ONE_CONV_OFM_BASE_EN
  assign base_in = ofm_base;
`else
  assign base_in = '0;
`endif

  assign dec      = decode_w_last(ofm_width);
  assign in_ready = (state_q == StRun) & (~wr_valid_q | wr_ready);
  assign accept   = in_valid & in_ready;

  one_conv_ofm_pos_cnt u_pos_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (cfg_load),
    .adv_i    (accept),
    .w_last_i (w_last_q),
    .h_last_i (h_last_q),
    .c_last_i (c_last_q),
    .w_wrap_o (w_wrap),
    .last_o   (pos_last)
  );

  always_comb begin
    state_d      = state_q;
    cfg_load     = 1'b0;
    cfg_err_d    = 1'b0;
    frame_done_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          if (dec.ok) begin
            state_d  = StRun;
            cfg_load = 1'b1;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (accept && pos_last) state_d = StDrain;
      end
      StDrain: begin
        if (wr_valid_q && wr_ready) begin
          state_d      = StIdle;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    addr_cnt_d = addr_cnt_q;
    if (cfg_load)    addr_cnt_d = '0;
    else if (accept) addr_cnt_d = addr_cnt_q + 1'b1;
    // A new accept reloads the register, so drain and refill share one cycle.
    wr_valid_d = wr_valid_q;
    if (accept)        wr_valid_d = 1'b1;
    else if (wr_ready) wr_valid_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      w_last_q     <= '0;
      h_last_q     <= '0;
      c_last_q     <= '0;
      base_q       <= '0;
      addr_cnt_q   <= '0;
      wr_valid_q   <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      row_done_q   <= 1'b0;
      frame_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_cnt_q   <= addr_cnt_d;
      wr_valid_q   <= wr_valid_d;
      row_done_q   <= accept & w_wrap;
      frame_done_q <= frame_done_d;
      cfg_err_q    <= cfg_err_d;
      if (cfg_load) begin
        w_last_q <= dec.w_last;
        h_last_q <= ofm_width - 9'd1;
        c_last_q <= ofm_channel - 11'd1;
        base_q   <= base_in;
      end
      if (accept) begin
        wr_addr_q <= base_q + addr_cnt_q;
        wr_data_q <= in_data;
      end
    end
  end

  assign wr_valid   = wr_valid_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign row_done   = row_done_q;
  assign frame_done = frame_done_q;
  assign cfg_err    = cfg_err_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_one_conv_ofm_writer.sv
// Randomized self-checking bench for one_conv_ofm_writer against a loop-nest address model.
module tb_one_conv_ofm_writer;

  localparam int DW = 64;
  localparam int AW = 24;
`ifdef ONE_CONV_OFM_BASE_EN
  localparam int unsigned BASE = 32'h1000;
`else
  localparam int unsigned BASE = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [8:0]    ofm_width = '0;
  logic [10:0]   ofm_channel = '0;
`ifdef ONE_CONV_OFM_BASE_EN
  logic [AW-1:0] ofm_base = AW'(BASE);
`endif
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          wr_valid;
  logic          wr_ready = 1'b1;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          row_done, frame_done, busy, cfg_err;

  one_conv_ofm_writer #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .ofm_width   (ofm_width),
    .ofm_channel (ofm_channel),
`ifdef ONE_CONV_OFM_BASE_EN
    .ofm_base    (ofm_base),
`endif
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .row_done    (row_done),
    .frame_done  (frame_done),
    .busy        (busy),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit bp = 1'b0;

  // Observation state, sampled mid-cycle.
  int cyc = 0;
  int row_cnt, frame_cnt, cfg_cnt, stall_viol, busy_seen, ready_seen, last_hs_cyc, frame_cyc;
  logic [AW-1:0] got_addr[$];
  logic [DW-1:0] got_data[$];
  logic          prev_stall;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_data;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall && (!wr_valid || wr_addr !== prev_addr || wr_data !== prev_data))
        stall_viol++;
      prev_stall = wr_valid && !wr_ready;
      prev_addr  = wr_addr;
      prev_data  = wr_data;
      if (wr_valid && wr_ready) begin
        got_addr.push_back(wr_addr);
        got_data.push_back(wr_data);
        last_hs_cyc = cyc;
      end
      if (row_done) row_cnt++;
      if (frame_done) begin
        frame_cnt++;
        frame_cyc = cyc;
      end
      if (cfg_err) cfg_cnt++;
      if (busy) busy_seen++;
      if (in_ready) ready_seen++;
    end
  end

  task automatic clear_mon();
    row_cnt = 0; frame_cnt = 0; cfg_cnt = 0; stall_viol = 0;
    busy_seen = 0; ready_seen = 0; last_hs_cyc = -10; frame_cyc = -10;
    prev_stall = 1'b0;
    got_addr.delete();
    got_data.delete();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    wr_ready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
  endtask

  task automatic start_layer(input int w, input int ch);
    ofm_width   = 9'(w);
    ofm_channel = 11'(ch);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Full layer: every chunk's address follows base + (oc*W + h)*(W/13) + x.
  task automatic run_layer(input int w, input int ch);
    int cpr = w / 13;
    int n = cpr * w * ch;
    int guard;
    bit acc;
    bit tmo = 1'b0;
    logic [AW-1:0] exp_addr[$];
    logic [DW-1:0] exp_data[$];
    clear_mon();
    for (int oc = 0; oc < ch; oc++)
      for (int h = 0; h < w; h++)
        for (int x = 0; x < cpr; x++) begin
          exp_addr.push_back(AW'(BASE + (oc * w + h) * cpr + x));
          exp_data.push_back({$urandom(), $urandom()});
        end
    start_layer(w, ch);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_after_start w=%0d got=%b want=1", w, busy);
    end
    for (int k = 0; k < n && !tmo; k++) begin
      if (bp && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        step();
      end
      in_valid = 1'b1;
      in_data  = exp_data[k];
      guard = 0;
      do begin
        @(negedge clk);
        acc = in_ready;
        step();
        guard++;
      end while (!acc && guard < 1000);
      if (!acc) tmo = 1'b1;
    end
    in_valid = 1'b0;
    total++;
    if (tmo) begin
      bad++;
      $display("FAIL accept_timeout w=%0d got=no_accept want=accept", w);
    end
    guard = 0;
    while (frame_cnt == 0 && guard < 1000) begin
      step();
      guard++;
    end
    step();
    step();
    total++;
    if (got_addr.size() != n) begin
      bad++;
      $display("FAIL write_count w=%0d got=%0d want=%0d", w, got_addr.size(), n);
    end
    for (int i = 0; i < n && i < got_addr.size(); i++) begin
      total++;
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
        bad++;
        $display("FAIL write_%0d w=%0d got=%h/%h want=%h/%h", i, w, got_addr[i], got_data[i],
                 exp_addr[i], exp_data[i]);
      end
      if (i > 0) begin
        total++;
        if (got_addr[i] <= got_addr[i-1]) begin
          bad++;
          $display("FAIL addr_increasing_%0d got=%h prev=%h want=greater", i, got_addr[i],
                   got_addr[i-1]);
        end
      end
    end
    total++;
    if (row_cnt != ch * w) begin
      bad++;
      $display("FAIL row_done_count w=%0d got=%0d want=%0d", w, row_cnt, ch * w);
    end
    total++;
    if (frame_cnt != 1) begin
      bad++;
      $display("FAIL frame_done_count w=%0d got=%0d want=1", w, frame_cnt);
    end
    total++;
    if (frame_cyc != last_hs_cyc + 1) begin
      bad++;
      $display("FAIL frame_done_timing w=%0d got=%0d want=%0d", w, frame_cyc, last_hs_cyc + 1);
    end
    total++;
    if (stall_viol != 0) begin
      bad++;
      $display("FAIL stall_stability w=%0d got=%0d want=0", w, stall_viol);
    end
    total++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_frame w=%0d got=busy%b/ready%b want=0/0", w, busy, in_ready);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    logic [AW+DW+7:0] obs;
    obs = {in_ready, wr_valid, wr_addr, wr_data, row_done, frame_done, busy, cfg_err};
    total++;
    if (obs !== '0) begin
      bad++;
      $display("FAIL %s got=%h want=0", tag, obs);
    end
    total++;
    if (wr_addr !== '0) begin
      bad++;
      $display("FAIL %s_wr_addr got=%h want=0", tag, wr_addr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset_values");
    rst = 1'b0;
    step();
  endtask

  task automatic test_w13();
    bp = 1'b0;
    run_layer(13, 2);
  endtask

  task automatic test_w416();
    logic [AW-1:0] a32, alast;
    bp = 1'b0;
    run_layer(416, 1);
    a32   = (got_addr.size() > 32) ? got_addr[32] : '1;
    alast = (got_addr.size() > 0) ? got_addr[got_addr.size()-1] : '1;
    total++;
    if (a32 !== AW'(BASE + 32)) begin
      bad++;
      $display("FAIL w416_chunk32 got=%h want=%h", a32, AW'(BASE + 32));
    end
    total++;
    if (alast !== AW'(BASE + 13311)) begin
      bad++;
      $display("FAIL w416_final got=%h want=%h", alast, AW'(BASE + 13311));
    end
  endtask

  task automatic test_backpressure();
    bp = 1'b1;
    run_layer(52, 3);
    run_layer(26, 2);
    bp = 1'b0;
    step();
  endtask

  task automatic test_cfg_err();
    bp = 1'b0;
    clear_mon();
    start_layer(100, 4);
    repeat (5) step();
    total++;
    if (cfg_cnt != 1) begin
      bad++;
      $display("FAIL cfg_err_pulse got=%0d want=1", cfg_cnt);
    end
    total++;
    if (busy_seen != 0 || ready_seen != 0) begin
      bad++;
      $display("FAIL cfg_err_idle got=busy%0d/ready%0d want=0/0", busy_seen, ready_seen);
    end
  endtask

  task automatic test_mid_reset();
    bp = 1'b0;
    clear_mon();
    start_layer(26, 1);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = {$urandom(), $urandom()};
      step();
    end
    rst = 1'b1;
    #1;
    check_zero_outputs("mid_reset");
    in_valid = 1'b0;
    step();
    rst = 1'b0;
    run_layer(26, 1);
    total++;
    if (got_addr.size() == 0 || got_addr[0] !== AW'(BASE)) begin
      bad++;
      $display("FAIL restart_addr got=%h want=%h", (got_addr.size() > 0) ? got_addr[0] : '1,
               AW'(BASE));
    end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_w13();
    test_cfg_err();
    test_backpressure();
    test_mid_reset();
    test_w416();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
